dram_responder: RTL and testbench
=================================

DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 Parameter MEM_WORDS, default 4096, depth of internal 32-bit word array (power of 2).
REQ-002 Parameter LATENCY, default 4, cycles from request acceptance to completion (range 2..255).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_X  input  1  reset, asynchronous, active-low.
REQ-005 i_addr  input  32  byte address of request.
REQ-006 i_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 i_we  input  1  store request, one-cycle pulse.
REQ-008 i_le  input  1  load request, one-cycle pulse.
REQ-009 i_ctrl  input  3  access type: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; stores use [1:0] only.
REQ-010 o_rdata  output  32  load result, extended to 32 bits.
REQ-011 o_busy  output  1  request in progress; new requests ignored while high.
REQ-012 o_err  output  1  sticky misaligned-access flag (meaningful only with DRAM_RESP_MISALIGN_EN).

Function
REQ-013 States IDLE, WAIT, ACCESS, DONE; reset state IDLE.
REQ-014 Request accepted at edge N when state is IDLE and i_we or i_le is 1; addr, wdata, ctrl, type latched at edge N.
REQ-015 i_we and i_le both 1 at acceptance: store executed, load dropped.
REQ-016 i_we or i_le while state not IDLE: ignored, no state change, no latch.
REQ-017 o_busy registered: 1 from edge N through edge N+LATENCY-1, 0 after edge N+LATENCY; 0 in IDLE.
REQ-018 WAIT: 8-bit counter loaded with LATENCY-2 at acceptance, decremented each cycle; at 0 go ACCESS.
REQ-019 ACCESS: one array access at word index addr[log2(MEM_WORDS)+1:2]; upper address bits ignored (wrap modulo MEM_WORDS*4 bytes); next state DONE.
REQ-020 DONE: o_rdata updated (loads only), o_busy cleared, next state IDLE; DONE lasts exactly one cycle.
REQ-021 Store byte enables: byte -> lane addr[1:0]; half -> lanes addr[1]*2 and +1; word -> all 4; unselected bytes unchanged.
REQ-022 Load extraction: select lane(s) by addr[1:0]/addr[1]; sign-extend for 000/001, zero-extend for 100/101; word unchanged.
REQ-023 Undefined i_ctrl codes (011, 110, 111): treated as word access.
REQ-024 o_rdata holds last load result until next completed load; stores do not alter o_rdata.
REQ-025 Back-to-back: new request may be accepted in the cycle after DONE (state IDLE); minimum request period LATENCY+1 cycles.

Reset
REQ-026 RST_X low: state IDLE, counter 0, o_busy 0, o_rdata 0, o_err 0, latched request fields 0, immediately and independent of CLK.
REQ-027 Reset mid-operation: pending request abandoned; store in WAIT not performed; array contents not cleared.
REQ-028 First request accepted at first rising edge with RST_X high.

Configuration
REQ-029 Macro DRAM_RESP_MISALIGN_EN.
REQ-030 Defined: half with addr[0]=1 or word with addr[1:0]!=0 sets o_err (sticky until reset), completes with normal busy timing, no array write, o_rdata unchanged.
REQ-031 Undefined: misalignment ignored; low bits forced (half uses addr[1], word uses addr[1:0]=00); o_err tied 0.

Verification
REQ-032 Word store 0xDEADBEEF to 0x100, then word load 0x100 -> o_busy high LATENCY cycles each, o_rdata=0xDEADBEEF after second busy fall.
REQ-033 Store byte 0x80 to 0x103 over word 0x11223344, load signed byte 0x103 -> 0xFFFFFF80; load unsigned byte -> 0x00000080; load word -> 0x80223344.
REQ-034 i_le pulse 2 cycles after an accepted store -> ignored; o_rdata unchanged, only one busy window.
REQ-035 i_we and i_le together, wdata 0x5A5A5A5A to 0x40 -> word at 0x40=0x5A5A5A5A, o_rdata unchanged.
REQ-036 RST_X low during WAIT of store 0x12345678 to 0x80 -> o_busy 0 immediately, later load 0x80 returns prior contents.
REQ-037 With DRAM_RESP_MISALIGN_EN, word load at 0x102 -> o_err=1, o_rdata unchanged; without, same load returns word at 0x100.

Source files
------------

// File: rtl/dram_responder.sv
// dram_responder: fixed-latency single-port memory responder with byte/half/word
// stores and sign/zero-extended loads. One request in flight at a time.
// Optional build macro DRAM_RESP_MISALIGN_EN: misaligned half/word accesses set a
// sticky o_err and complete without touching memory or o_rdata. When the macro is
// undefined, the low address bits are simply ignored for half/word accesses.
module dram_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 4
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic        i_le,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_err
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          accept;
  // Only the bits that select a word and a lane are kept; upper address bits wrap.
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    ctrl_q;
  logic          we_q;
  logic [31:0]   rword_q;
  logic [31:0]   rdata_q;
  logic          busy_q;
  logic [31:0]   mem [MEM_WORDS];

  logic          is_byte, is_half, misal;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   shifted;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic [AW-1:0] idx;

  // Access size: [1:0]=00 byte, 01 half, anything else is a word.
  assign is_byte = (ctrl_q[1:0] == 2'b00);
  assign is_half = (ctrl_q[1:0] == 2'b01);
  assign idx     = addr_q[AW+1:2];

`ifdef DRAM_RESP_MISALIGN_EN
  assign misal = (is_half && addr_q[0]) ||
                 (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be    = 4'hF;
    wlane = wdata_q;
    if (is_byte) begin
      be             = 4'h0;
      be[addr_q[1:0]] = 1'b1;
      wlane          = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      be    = addr_q[1] ? 4'b1100 : 4'b0011;
      wlane = {2{wdata_q[15:0]}};
    end
  end

  // Load lane extraction and sign/zero extension (ctrl[2]=1 means unsigned).
  always_comb begin
    shifted = rword_q >> {addr_q[1:0], 3'b000};
    ld_half = addr_q[1] ? rword_q[31:16] : rword_q[15:0];
    if (is_byte)
      ld_val = {{24{~ctrl_q[2] & shifted[7]}}, shifted[7:0]};
    else if (is_half)
      ld_val = {{16{~ctrl_q[2] & ld_half[15]}}, ld_half};
    else
      ld_val = rword_q;
  end

  // Next-state logic; WAIT is skipped entirely when LATENCY is 2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_we || i_le) begin
          accept  = 1'b1;
          cnt_d   = 8'(LATENCY - 2);
          state_d = (LATENCY == 2) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_d == 8'd0) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state, request latch and registered outputs.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= i_addr[AW+1:0];
        wdata_q <= i_wdata;
        ctrl_q  <= i_ctrl;
        we_q    <= i_we;
        busy_q  <= 1'b1;
      end
      if (state_q == S_DONE) begin
        busy_q <= 1'b0;
        if (!we_q && !misal) rdata_q <= ld_val;
      end
    end
  end

`ifdef DRAM_RESP_MISALIGN_EN
  logic err_q;
  // Sticky misalignment flag, raised when the offending access reaches ACCESS.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)                              err_q <= 1'b0;
    else if (state_q == S_ACCESS && misal)   err_q <= 1'b1;
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // Memory array: not reset, so contents survive a mid-operation reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_ACCESS) begin
      if (we_q && !misal) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
      rword_q <= mem[idx];
    end
  end

  assign o_rdata = rdata_q;
  assign o_busy  = busy_q;
endmodule

// File: tb/tb_dram_responder.sv
// Randomized bench for dram_responder against a byte-addressed reference model.
module tb_dram_responder;
  localparam int MW  = 256;
  localparam int LAT = 5;
  localparam int NB  = MW * 4;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        i_we = 1'b0, i_le = 1'b0;
  logic [2:0]  i_ctrl = '0;
  logic [31:0] o_rdata;
  logic        o_busy, o_err;

  dram_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST_X(RST_X), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_we(i_we), .i_le(i_le), .i_ctrl(i_ctrl),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0, n_mis = 0;
  logic [7:0]  mb [NB];
  logic [31:0] rdata_m = '0;
  logic        err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_misal(input logic [31:0] a, input logic [2:0] c);
`ifdef DRAM_RESP_MISALIGN_EN
    return (c[1:0] == 2'b01 && a[0]) || (c[1:0][1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] c);
    int unsigned b = a & (NB - 1);
    logic [15:0] h;
    case (c[1:0])
      2'b00: return c[2] ? {24'b0, mb[b]} : {{24{mb[b][7]}}, mb[b]};
      2'b01: begin
        b = b & ~32'd1;
        h = {mb[b+1], mb[b]};
        return c[2] ? {16'b0, h} : {{16{h[15]}}, h};
      end
      default: begin
        b = b & ~32'd3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      end
    endcase
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] c);
    int unsigned b = a & (NB - 1);
    case (c[1:0])
      2'b00: mb[b] = wd[7:0];
      2'b01: begin
        b = b & ~32'd1;
        mb[b] = wd[7:0]; mb[b+1] = wd[15:8];
      end
      default: begin
        b = b & ~32'd3;
        for (int k = 0; k < 4; k++) mb[b+k] = wd[8*k +: 8];
      end
    endcase
  endtask

  // Drive one request pulse; returns #1 after the accepting edge, model updated.
  task automatic issue(input bit we, input bit le, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] c);
    @(negedge CLK);
    i_addr = a; i_wdata = wd; i_ctrl = c; i_we = we; i_le = le;
    @(posedge CLK); #1;
    i_we = 1'b0; i_le = 1'b0;
    if (m_misal(a, c)) err_m = 1'b1;
    else if (we) m_store(a, wd, c);
    else if (le) rdata_m = m_load(a, c);
  endtask

  // Count busy samples (n0 already elapsed), then check outputs.
  task automatic finish(input string tag, input int n0);
    int n = n0;
    while (o_busy && n < 300) begin
      n++;
      @(posedge CLK); #1;
    end
    chk({tag, "_busylen"}, n, LAT);
    chk({tag, "_rdata"}, o_rdata, rdata_m);
    chk({tag, "_err"}, {31'b0, o_err}, {31'b0, err_m});
  endtask

  logic [31:0] prev, exp37;
  logic [2:0]  c;
  int          op;

  initial begin
    #12;
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    @(negedge CLK) RST_X = 1'b1;

    for (int i = 0; i < MW; i++) begin
      issue(1, 0, i * 4, $urandom, 3'b010);
      finish("init", 0);
    end

    issue(1, 0, 32'h100, 32'hDEADBEEF, 3'b010); finish("r32s", 0);
    issue(0, 1, 32'h100, 32'h0, 3'b010);        finish("r32l", 0);
    chk("r32", o_rdata, 32'hDEADBEEF);

    issue(1, 0, 32'h100, 32'h11223344, 3'b010); finish("r33w", 0);
    issue(1, 0, 32'h103, 32'h00000080, 3'b000); finish("r33b", 0);
    issue(0, 1, 32'h103, 32'h0, 3'b000);        finish("r33ls", 0);
    chk("r33_sbyte", o_rdata, 32'hFFFFFF80);
    issue(0, 1, 32'h103, 32'h0, 3'b100);        finish("r33lu", 0);
    chk("r33_ubyte", o_rdata, 32'h00000080);
    issue(0, 1, 32'h100, 32'h0, 3'b010);        finish("r33lw", 0);
    chk("r33_word", o_rdata, 32'h80223344);

    // Load pulse two cycles into a store must be ignored.
    issue(1, 0, 32'h20, 32'hCAFEF00D, 3'b010);
    @(posedge CLK); @(negedge CLK);
    i_addr = 32'h100; i_ctrl = 3'b010; i_le = 1'b1;
    @(posedge CLK); #1; i_le = 1'b0;
    finish("r34", 2);
    @(posedge CLK); #1;
    chk("r34_nosecond", {31'b0, o_busy}, 32'd0);

    issue(1, 1, 32'h40, 32'h5A5A5A5A, 3'b010); finish("r35", 0);
    issue(0, 1, 32'h40, 32'h0, 3'b010);        finish("r35l", 0);
    chk("r35_word", o_rdata, 32'h5A5A5A5A);

    // Reset while the store sits in WAIT: store must not land.
    prev = m_load(32'h80, 3'b010);
    issue(1, 0, 32'h80, 32'h12345678, 3'b010);
    m_store(32'h80, prev, 3'b010);
    @(posedge CLK); #1;
    RST_X = 1'b0; #1;
    chk("r36_busy", {31'b0, o_busy}, 32'd0);
    chk("r36_rdata", o_rdata, 32'd0);
    rdata_m = '0; err_m = 1'b0;
    @(negedge CLK) RST_X = 1'b1;
    issue(0, 1, 32'h80, 32'h0, 3'b010); finish("r36l", 0);
    chk("r36_prior", o_rdata, prev);

`ifdef DRAM_RESP_MISALIGN_EN
    exp37 = rdata_m;
`else
    exp37 = m_load(32'h100, 3'b010);
`endif
    issue(0, 1, 32'h102, 32'h0, 3'b010); finish("r37", 0);
    chk("r37_rdata", o_rdata, exp37);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      c  = 3'($urandom_range(0, 7));
      if (op < 4)      issue(1, 0, $urandom, $urandom, c);
      else if (op < 9) issue(0, 1, $urandom, $urandom, c);
      else             issue(1, 1, $urandom, $urandom, c);
      finish("rnd", 0);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
